// File: rtl/note_pkg.sv
// note_pkg: shared definitions for the note recorder and playback blocks.
//   NOTE_W      width of a keypad note code
//   NOTE_REST   the code for silence
//   rec_state_t recorder FSM states
//   is_rest()   true when a note code is the rest code
package note_pkg;
   localparam int NOTE_W = 5;
   localparam logic [NOTE_W-1:0] NOTE_REST = 5'b00000;

   typedef enum logic [1:0] {IDLE, ARMED, REC, DONE} rec_state_t;

   function automatic logic is_rest(input logic [NOTE_W-1:0] n);
      return n == NOTE_REST;
   endfunction
endpackage

// File: rtl/beat_tick_gen.sv
// beat_tick_gen: free-running beat divider, clk domain only (no derived clock).
//   clk, rst_n  clock, synchronous active-low reset
//   en          count enable; while low the count holds and tick stays low
//   clr         synchronous clear of the count (wins over en)
//   tick        one-cycle strobe while the count sits at BEAT_DIV-1
// The first tick after clr comes BEAT_DIV cycles after the clr cycle.
module beat_tick_gen #(
   parameter int BEAT_DIV = 6_250_000,
   localparam int CW = $clog2(BEAT_DIV)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/note_recorder.sv
// note_recorder: records one keypad note per beat into a score buffer and
// serves it back through a synchronous read port for playback.
//   clk, rst_n  clock, synchronous active-low reset
//   note_in     live note code (0 = rest)
//   rec_start   pulse: clear pointers and arm (honoured in every state)
//   rec_stop    pulse: end recording (rec_start wins if both)
//   pause       level: freeze beat counter and writes
//   rd_addr     playback read address
//   rd_note     mem[rd_addr] one cycle later, 0 beyond rec_len
//   rec_len     valid recorded beats (0 while armed/recording)
//   recording   high in ARMED or REC
//   full        buffer filled, sticky until rec_start or reset
//   beat        one-cycle beat strobe
// Optional build macro NOTE_REC_TRIM_EN: trailing rests are trimmed from rec_len.
module note_recorder import note_pkg::*; #(
   parameter int BEAT_DIV = 6_250_000,
   parameter int DEPTH    = 256,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NOTE_W-1:0] note_in,
   input  logic              rec_start,
   input  logic              rec_stop,
   input  logic              pause,
   input  logic [AW-1:0]     rd_addr,
   output logic [NOTE_W-1:0] rd_note,
   output logic [AW:0]       rec_len,
   output logic              recording,
   output logic              full,
   output logic              beat
);
   rec_state_t state, state_nxt;
   logic [AW:0] wr_ptr, wr_ptr_nxt, rec_len_nxt;
   logic        full_nxt, wr_en, tick;
`ifdef NOTE_REC_TRIM_EN
   logic [AW:0] last_nz, last_nz_nxt;
`endif

   logic [NOTE_W-1:0] mem [DEPTH];

   assign recording = (state == ARMED) || (state == REC);
   assign beat      = tick;

   beat_tick_gen #(.BEAT_DIV(BEAT_DIV)) u_beat (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (recording && !pause),
      .clr   (rec_start),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      wr_ptr_nxt  = wr_ptr;
      rec_len_nxt = rec_len;
      full_nxt    = full;
      wr_en       = 1'b0;
`ifdef NOTE_REC_TRIM_EN
      last_nz_nxt = last_nz;
`endif
      if (rec_start) begin
         state_nxt   = ARMED;
         wr_ptr_nxt  = '0;
         rec_len_nxt = '0;
         full_nxt    = 1'b0;
`ifdef NOTE_REC_TRIM_EN
         last_nz_nxt = '0;
`endif
      end else begin
         case (state)
            ARMED, REC: begin
               // While ARMED, rests are dropped so leading silence is not stored.
               if (tick && (state == REC || !is_rest(note_in))) begin
                  wr_en      = 1'b1;
                  wr_ptr_nxt = wr_ptr + 1'b1;
                  state_nxt  = REC;
`ifdef NOTE_REC_TRIM_EN
                  if (!is_rest(note_in)) last_nz_nxt = wr_ptr + 1'b1;
`endif
                  if (wr_ptr == (AW+1)'(DEPTH - 1)) begin
                     full_nxt  = 1'b1;
                     state_nxt = DONE;
                  end
               end
               // A stop in a beat cycle still keeps that beat's write.
               if (rec_stop) state_nxt = DONE;
               if (state_nxt == DONE) begin
`ifdef NOTE_REC_TRIM_EN
                  rec_len_nxt = last_nz_nxt;
`else
                  rec_len_nxt = wr_ptr_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rec_len <= '0;
         full    <= 1'b0;
`ifdef NOTE_REC_TRIM_EN
         last_nz <= '0;
`endif
      end else begin
         wr_ptr  <= wr_ptr_nxt;
         rec_len <= rec_len_nxt;
         full    <= full_nxt;
`ifdef NOTE_REC_TRIM_EN
         last_nz <= last_nz_nxt;
`endif
      end
   end

   // Buffer has no reset so it maps to a plain dual-port RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n) mem[wr_ptr[AW-1:0]] <= note_in;
   end

   // Read-first: a same-cycle write to rd_addr is seen on the following read.
   always_ff @(posedge clk) begin
      if (!rst_n)
         rd_note <= NOTE_REST;
      else
         rd_note <= ({1'b0, rd_addr} < rec_len) ? mem[rd_addr] : NOTE_REST;
   end
endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;
   localparam int BEAT_DIV = 4;
   localparam int DEPTH    = 16;
   localparam int AW       = 4;

   logic          clk = 1'b0;
   logic          rst_n, rec_start, rec_stop, pause;
   logic [4:0]    note_in, rd_note;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   rec_len;
   logic          recording, full, beat;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [4:0]    exp;
   } rd_vec_t;
   rd_vec_t vecs [5];

   note_recorder #(.BEAT_DIV(BEAT_DIV), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .note_in(note_in), .rec_start(rec_start),
      .rec_stop(rec_stop), .pause(pause), .rd_addr(rd_addr), .rd_note(rd_note),
      .rec_len(rec_len), .recording(recording), .full(full), .beat(beat)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      rec_start = 1'b1;
      step(1);
      rec_start = 1'b0;
   endtask

   task automatic pulse_stop();
      rec_stop = 1'b1;
      step(1);
      rec_stop = 1'b0;
   endtask

   // Wait for the next beat strobe with note n on note_in, optionally asserting
   // rec_stop in the beat cycle; exp_wait<0 skips the latency check.
   task automatic do_beat(input logic [4:0] n, input logic stop, input int exp_wait);
      int waited;
      note_in = n;
      waited  = 0;
      while (!beat && waited < 20) begin
         step(1);
         waited++;
      end
      if (!beat) begin
         failures++;
         checks++;
         $display("FAIL beat_timeout: no beat within %0d cycles", waited);
      end
      if (exp_wait >= 0) chk("beat_latency", waited, exp_wait);
      rec_stop = stop;
      step(1);
      rec_stop = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [4:0] e);
      rd_addr = a;
      step(1);
      chk(name, rd_note, e);
   endtask

   initial begin
      int exp_len;
      rst_n = 1'b0; rec_start = 1'b0; rec_stop = 1'b0; pause = 1'b0;
      note_in = 5'd0; rd_addr = '0;

      // Reset state
      step(2);
      chk("rst_rec_len", rec_len, 0);
      chk("rst_recording", recording, 0);
      chk("rst_full", full, 0);
      chk("rst_beat", beat, 0);
      chk("rst_rd_note", rd_note, 0);
      rst_n = 1'b1;
      step(1);

      // 1: leading silence dropped, then three notes
      pulse_start();
      chk("t1_recording", recording, 1);
      do_beat(5'd0, 1'b0, BEAT_DIV - 1);
      do_beat(5'd0, 1'b0, BEAT_DIV - 1);
      do_beat(5'b01010, 1'b0, BEAT_DIV - 1);
      do_beat(5'b01010, 1'b0, -1);
      do_beat(5'b01010, 1'b0, -1);
      chk("t1_len_hidden", rec_len, 0);
      pulse_stop();
      chk("t1_done", recording, 0);
      chk("t1_rec_len", rec_len, 3);
      vecs[0] = '{addr: 4'd0,  exp: 5'b01010};
      vecs[1] = '{addr: 4'd1,  exp: 5'b01010};
      vecs[2] = '{addr: 4'd2,  exp: 5'b01010};
      vecs[3] = '{addr: 4'd3,  exp: 5'b00000};
      vecs[4] = '{addr: 4'd15, exp: 5'b00000};
      for (int i = 0; i < 5; i++) rd_chk($sformatf("t1_rd%0d", vecs[i].addr), vecs[i].addr, vecs[i].exp);

      // 2: fill buffer
      pulse_start();
      for (int i = 0; i < DEPTH - 1; i++) do_beat(5'b00101, 1'b0, -1);
      chk("t2_not_full_15", full, 0);
      chk("t2_rec_15", recording, 1);
      do_beat(5'b00101, 1'b0, -1);
      chk("t2_full", full, 1);
      chk("t2_done", recording, 0);
      chk("t2_rec_len", rec_len, 16);
      begin
         int beats_seen = 0;
         for (int i = 0; i < 3 * BEAT_DIV; i++) begin
            if (beat) beats_seen++;
            step(1);
         end
         chk("t2_no_beat_done", beats_seen, 0);
      end
      chk("t2_rec_len_hold", rec_len, 16);
      rd_chk("t2_rd15", 4'd15, 5'b00101);
      rd_chk("t2_rd0", 4'd0, 5'b00101);

      // 4: start+stop together in DONE -> start wins
      rec_start = 1'b1; rec_stop = 1'b1;
      step(1);
      rec_start = 1'b0; rec_stop = 1'b0;
      chk("t4_armed", recording, 1);
      chk("t4_rec_len", rec_len, 0);
      chk("t4_full", full, 0);

      // 3: pause mid-REC
      do_beat(5'b00111, 1'b0, BEAT_DIV - 1);
      step(1);
      pause = 1'b1;
      begin
         int beats_seen = 0;
         for (int i = 0; i < 10; i++) begin
            if (beat) beats_seen++;
            step(1);
         end
         chk("t3_no_beat_paused", beats_seen, 0);
      end
      pause = 1'b0;
      do_beat(5'b00111, 1'b0, BEAT_DIV - 2);
      do_beat(5'b00000, 1'b0, BEAT_DIV - 1);
      pulse_stop();
`ifdef NOTE_REC_TRIM_EN
      exp_len = 2;
`else
      exp_len = 3;
`endif
      chk("t3_rec_len", rec_len, exp_len);
      rd_chk("t3_rd0", 4'd0, 5'b00111);
      rd_chk("t3_rd1", 4'd1, 5'b00111);

      // 5: trailing rests
      pulse_start();
      do_beat(5'b01000, 1'b0, -1);
      do_beat(5'b00000, 1'b0, -1);
      do_beat(5'b00000, 1'b0, -1);
      pulse_stop();
`ifdef NOTE_REC_TRIM_EN
      exp_len = 1;
`else
      exp_len = 3;
`endif
      chk("t5_rec_len", rec_len, exp_len);
      rd_chk("t5_rd0", 4'd0, 5'b01000);

      // stop in the same cycle as a beat keeps that beat's write
      pulse_start();
      do_beat(5'b00001, 1'b0, -1);
      do_beat(5'b00010, 1'b1, -1);
      chk("tsb_done", recording, 0);
      chk("tsb_rec_len", rec_len, 2);
      rd_chk("tsb_rd1", 4'd1, 5'b00010);

      // 6: reset mid-REC
      pulse_start();
      do_beat(5'b00011, 1'b0, -1);
      do_beat(5'b00100, 1'b0, -1);
      step(1);
      chk("t6_pre_rec", recording, 1);
      rst_n = 1'b0;
      step(1);
      chk("t6_rec_len", rec_len, 0);
      chk("t6_recording", recording, 0);
      chk("t6_full", full, 0);
      chk("t6_beat", beat, 0);
      chk("t6_rd_note", rd_note, 0);
      rst_n = 1'b1;
      begin
         int beats_seen = 0;
         for (int i = 0; i < 3 * BEAT_DIV; i++) begin
            if (beat) beats_seen++;
            step(1);
         end
         chk("t6_idle_no_beat", beats_seen, 0);
      end
      chk("t6_idle", recording, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
